// File: rtl/fifo_pkg.sv
// Shared definitions for the async register-file FIFO controllers.
// Gray helpers are width-generic: callers zero-extend in and truncate out.
package fifo_pkg;

    localparam int DEF_DEPTH  = 4;
    localparam int DEF_UWIDTH = 8;
    localparam int DEF_ADDR_W = $clog2(DEF_DEPTH);
    localparam int GW         = 32;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    function automatic logic [GW-1:0] bin2gray(input logic [GW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Zero upper bits contribute nothing to the prefix XOR.
    function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
        logic [GW-1:0] b;
        b = g;
        for (int i = 1; i < GW; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_sync.sv
// Multi-flop synchroniser for a Gray pointer crossing clock domains.
// Also used by the write side for the read pointer.
module fifo_sync #(
    parameter int WIDTH  = 3,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] sr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr <= '0;
        end else begin
            sr <= {sr[STAGES-2:0], d};
        end
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/fifo_read_logic.sv
// Read-domain controller of the async FIFO: empty/occupancy, read
// pointer, and a first-word-fall-through output register.
module fifo_read_logic
    import fifo_pkg::*;
#(
    parameter int DEPTH       = DEF_DEPTH,
    parameter int UWIDTH      = DEF_UWIDTH,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W:0]   wptr_gray,
    input  logic [UWIDTH-1:0] rdata_mem,
    input  logic              dout_ready,
    output logic [ADDR_W-1:0] raddr,
    output logic              ren,
    output logic [ADDR_W:0]   rptr_gray,
    output logic              rempty,
    output logic [ADDR_W:0]   rcount,
    output logic [UWIDTH-1:0] dout,
    output logic              dout_valid
);

    localparam int PW = ADDR_W + 1;

    logic [PW-1:0]     rbin;
    logic [PW-1:0]     rbin_next;
    logic [PW-1:0]     rnext_gray;
    logic [PW-1:0]     wq_gray;
    logic [PW-1:0]     wq_bin;
    out_state_t        state;
    out_state_t        state_next;
    logic [UWIDTH-1:0] dout_next;

    fifo_sync #(
        .WIDTH (PW),
        .STAGES(SYNC_STAGES)
    ) u_wsync (
        .clk(clk),
        .rst(rst),
        .d  (wptr_gray),
        .q  (wq_gray)
    );

    assign wq_bin     = PW'(gray2bin(GW'(wq_gray)));
    assign dout_valid = (state == OUT_FULL);
    assign ren        = !rempty && (!dout_valid || dout_ready);
    assign rbin_next  = rbin + {{ADDR_W{1'b0}}, ren};
    assign rnext_gray = PW'(bin2gray(GW'(rbin_next)));
    assign raddr      = rbin[ADDR_W-1:0];

    // Flags compare against the post-read pointer so a same-cycle
    // arrival and last read resolve without loss or duplication.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rbin      <= '0;
            rptr_gray <= '0;
            rempty    <= 1'b1;
            rcount    <= '0;
        end else begin
            rbin      <= rbin_next;
            rptr_gray <= rnext_gray;
            rempty    <= (rnext_gray == wq_gray);
            rcount    <= wq_bin - rbin_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= OUT_EMPTY;
            dout  <= '0;
        end else begin
            state <= state_next;
            dout  <= dout_next;
        end
    end

    always_comb begin
        state_next = state;
        dout_next  = dout;
        unique case (state)
            OUT_EMPTY: begin
                if (ren) begin
                    dout_next  = rdata_mem;
                    state_next = OUT_FULL;
                end
            end
            OUT_FULL: begin
                if (dout_ready) begin
                    if (ren) begin
                        dout_next = rdata_mem;
                    end else begin
                        state_next = OUT_EMPTY;
                    end
                end
            end
            default: state_next = OUT_EMPTY;
        endcase
    end

endmodule

// File: doc/fifo_read_logic.md
# fifo_read_logic

Read-side controller of the asynchronous register-file FIFO, running in the read clock domain. It is the downstream peer of the write-side controller. It synchronises the write-domain Gray pointer, derives the empty flag and occupancy, and drives the storage read address. It returns its own Gray read pointer to the write side and presents data through a first-word-fall-through output register with a valid/ready handshake.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- UWIDTH, 8, entry width in bits
- ADDR_W, 2, log2(DEPTH); pointers are ADDR_W+1 bits, with the extra bit as the wrap bit
- SYNC_STAGES, 2, flop stages in the write-pointer synchroniser; ≥ 2
- clk  in  1  read-domain clock
- rst  in  1  asynchronous, active-low reset
- wptr_gray  in  ADDR_W+1  write pointer, Gray coded, from the write domain (asynchronous)
- rdata_mem  in  UWIDTH  storage read data; combinational read of entry raddr
- dout_ready  in  1  consumer accepts dout this cycle
- raddr  out  ADDR_W  storage read address, equal to rbin[ADDR_W-1:0]
- ren  out  1  storage word consumed this cycle (combinational)
- rptr_gray  out  ADDR_W+1  registered Gray read pointer, sent to the write domain
- rempty  out  1  storage empty (registered); excludes the output register
- rcount  out  ADDR_W+1  registered storage occupancy, 0..DEPTH
- dout  out  UWIDTH  output data register
- dout_valid  out  1  dout holds a valid word

## Operation
- **Synchroniser:** wptr_gray passes through SYNC_STAGES flops to give wq_gray, which is converted to binary as wq_bin.
- **Read pointer:** rbin is ADDR_W+1 bits, binary. It increments by 1 on ren and wraps modulo 2^(ADDR_W+1). rptr_gray = bin2gray(rbin), registered alongside rbin.
- **ren** = !rempty && (!dout_valid || dout_ready). ren is never asserted while rempty=1.
- **Output FSM, two states:**
  - OUT_EMPTY (dout_valid=0): on ren, load dout <= rdata_mem and go to OUT_FULL.
  - OUT_FULL (dout_valid=1), when dout_ready=1: on ren, reload dout and stay; on !ren, go to OUT_EMPTY.
  - OUT_FULL, when dout_ready=0: hold dout and state.
- **Empty flag:** rempty <= (bin2gray(rbin_next) == wq_gray) every cycle, where rbin_next = rbin + ren.
- **Occupancy:** rcount <= wq_bin − rbin_next, modulo 2^(ADDR_W+1).
- **Reset values:** rbin=0, rptr_gray=0, synchroniser flops=0, rempty=1, rcount=0, dout=0, dout_valid=0, state OUT_EMPTY. raddr=0 and ren=0 follow from these.
- **Reset mid-operation:** asynchronous clear of all of the above, with no drain. The write side is reset in the same event.
- **Wrap-around:** full and empty are distinguished only by the wrap bit. rptr_gray changes exactly one bit per increment, including the step from 2^(ADDR_W+1)−1 to 0.
- **Simultaneous events:**
  - Write arrival and the last read in the same cycle: rempty follows the freshly compared values, so no word is lost or duplicated.
  - dout_ready=1 with rempty=1: dout_valid drops on the next edge.

## Timing
- **Write-to-output latency:** with SYNC_STAGES=2, count edges from the first clk edge that samples a new wptr_gray.
  - Edge 1: first synchroniser stage captures it.
  - Edge 2: wq_gray updates.
  - Edge 3: rempty falls; ren=1 in the following cycle.
  - Edge 4: dout_valid=1.
  - Generally the latency is SYNC_STAGES+2 edges.
- **Read-to-write visibility:** rptr_gray updates on the edge that consumes ren. The write side sees it after its own synchroniser.
- **Throughput:** one word per cycle while storage is non-empty and dout_ready=1.
- **Pessimism:** rcount and rempty are pessimistic by the synchroniser latency and never report data that is not yet written.

## Structure
- **Package fifo_pkg:**
  - bin2gray and gray2bin functions, parameterised on width.
  - OUT_EMPTY/OUT_FULL state encodings.
  - Default DEPTH/UWIDTH/ADDR_W constants, shared with the write-side controller.
- **Sub-module fifo_sync:** WIDTH and STAGES parameters, async active-low reset to 0. The write side reuses it for the read pointer.

## Test plan
- **Reset:** assert rst low while dout_valid=1 and rcount=2 -> immediately rempty=1, dout_valid=0, rptr_gray=000, raddr=0, rcount=0.
- **Single word:** wptr_gray 000->001, rdata_mem=8'hA5, dout_ready=0 -> rempty=0 after edge 3, ren high for exactly one cycle, dout=8'hA5 and dout_valid=1 after edge 4 and held, rptr_gray=001, raddr=1.
- **Full drain:** wptr_gray=110 (4 words, DEPTH=4) with data 11,22,33,44 and dout_ready=1 -> dout takes 11,22,33,44 on consecutive cycles, then rempty=1, rcount=0, rptr_gray=110, dout_valid=0 one cycle later.
- **Backpressure:** 4 words stored, dout_ready=0 -> one word in dout, ren stays 0 afterwards, rcount=3, rptr_gray=001.
- **Wrap-around:** stream 10 words through DEPTH=4 with random dout_ready -> rptr_gray follows 000,001,011,010,110,111,101,100,000,001,011. Data order is preserved, and each rptr_gray step flips exactly one bit.
- **Occupancy:** write pointer at bin 3, rbin=0, no reads -> rcount=3 at edge 3 after the write. A simultaneous read and new write leave rcount unchanged.
